// File: rtl/div_ctrl_pkg.sv
// Shared constants and state encoding for the EX-stage divider sequencer.
// Handshake levels match the iterative divider's start/annul/ready signals.
package div_ctrl_pkg;

    localparam int DIV_WIDTH        = 32;
    localparam int DIV_ABORT_CYCLES = 2;

    localparam logic DIV_START        = 1'b1;
    localparam logic DIV_STOP         = 1'b0;
    localparam logic DIV_RESULT_READY = 1'b1;

    typedef enum logic [1:0] {
        DIVC_IDLE  = 2'd0,
        DIVC_BUSY  = 2'd1,
        DIVC_DRAIN = 2'd2,
        DIVC_ABORT = 2'd3
    } divc_state_e;

endpackage

// File: rtl/div_fast_path.sv
// Trivial-division detect: divisor of one or zero dividend needs no iteration.
// Correct for signed and unsigned operands alike; remainder is always zero.
module div_fast_path #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             hit,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic div_by_one;

    assign div_by_one = (op2 == WIDTH'(1));
    assign hit        = div_by_one || (op1 == '0);
    assign lo         = div_by_one ? op1 : '0;
    assign hi         = '0;

endmodule

// File: rtl/div_ctrl.sv
// Sequencer between EX and the iterative divider: latch, start/annul, stall, HI/LO write.
// Optional build macro DIV_FAST_PATH_EN bypasses the divider for x/1 and 0/x.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH        = DIV_WIDTH,
    parameter int ABORT_CYCLES = DIV_ABORT_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_div_i,
    input  logic               ex_signed_i,
    input  logic [WIDTH-1:0]   ex_op1_i,
    input  logic [WIDTH-1:0]   ex_op2_i,
    input  logic               flush_i,
    output logic               stall_o,
    output logic               div_start_o,
    output logic               div_annul_o,
    output logic               div_signed_o,
    output logic [WIDTH-1:0]   div_op1_o,
    output logic [WIDTH-1:0]   div_op2_o,
    input  logic [2*WIDTH-1:0] div_result_i,
    input  logic               div_ready_i,
    output logic               hilo_we_o,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o
);

    localparam int CNT_W = (ABORT_CYCLES > 1) ? $clog2(ABORT_CYCLES) : 1;

    divc_state_e      state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             fast, fast_n;
    logic             start_n, annul_n, signed_n, we_n;
    logic [WIDTH-1:0] op1_n, op2_n, hi_n, lo_n;
    logic             fp_hit;
    logic [WIDTH-1:0] fp_hi, fp_lo;

`ifdef DIV_FAST_PATH_EN
    div_fast_path #(.WIDTH(WIDTH)) u_fast_path (
        .op1 (ex_op1_i),
        .op2 (ex_op2_i),
        .hit (fp_hit),
        .hi  (fp_hi),
        .lo  (fp_lo)
    );
`else
    assign fp_hit = 1'b0;
    assign fp_hi  = '0;
    assign fp_lo  = '0;
`endif

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        fast_n   = fast;
        start_n  = div_start_o;
        annul_n  = 1'b0;
        signed_n = div_signed_o;
        op1_n    = div_op1_o;
        op2_n    = div_op2_o;
        we_n     = 1'b0;
        hi_n     = hi_o;
        lo_n     = lo_o;
        stall_o  = 1'b0;

        case (state)
            DIVC_IDLE: begin
                if (ex_div_i && !flush_i) begin
                    stall_o  = 1'b1;
                    signed_n = ex_signed_i;
                    op1_n    = ex_op1_i;
                    op2_n    = ex_op2_i;
                    if (fp_hit) begin
                        we_n    = 1'b1;
                        hi_n    = fp_hi;
                        lo_n    = fp_lo;
                        fast_n  = 1'b1;
                        state_n = DIVC_DRAIN;
                    end else begin
                        start_n = DIV_START;
                        fast_n  = 1'b0;
                        state_n = DIVC_BUSY;
                    end
                end
            end
            DIVC_BUSY: begin
                stall_o = (div_ready_i != DIV_RESULT_READY);
                if (flush_i) begin
                    start_n = DIV_STOP;
                    annul_n = 1'b1;
                    cnt_n   = '0;
                    state_n = DIVC_ABORT;
                end else if (div_ready_i == DIV_RESULT_READY) begin
                    hi_n    = div_result_i[2*WIDTH-1:WIDTH];
                    lo_n    = div_result_i[WIDTH-1:0];
                    we_n    = 1'b1;
                    start_n = DIV_STOP;
                    state_n = DIVC_DRAIN;
                end
            end
            DIVC_DRAIN: begin
                // After a fast-path hit EX still holds the DIV just completed; let it go.
                stall_o = ex_div_i && !fast;
                fast_n  = 1'b0;
                state_n = DIVC_IDLE;
            end
            DIVC_ABORT: begin
                if (cnt == CNT_W'(ABORT_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = DIVC_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = DIVC_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= DIVC_IDLE;
            cnt          <= '0;
            fast         <= 1'b0;
            div_start_o  <= 1'b0;
            div_annul_o  <= 1'b0;
            div_signed_o <= 1'b0;
            div_op1_o    <= '0;
            div_op2_o    <= '0;
            hilo_we_o    <= 1'b0;
            hi_o         <= '0;
            lo_o         <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            fast         <= fast_n;
            div_start_o  <= start_n;
            div_annul_o  <= annul_n;
            div_signed_o <= signed_n;
            div_op1_o    <= op1_n;
            div_op2_o    <= op2_n;
            hilo_we_o    <= we_n;
            hi_o         <= hi_n;
            lo_o         <= lo_n;
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl with a behavioural iterative divider alongside.
// Build with +define+DIV_FAST_PATH_EN to also exercise the fast path.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_div = 1'b0, ex_signed = 1'b0, flush = 1'b0;
    logic [31:0] ex_op1 = '0, ex_op2 = '0;
    logic        stall, div_start, div_annul, div_signed, hilo_we;
    logic [31:0] div_op1, div_op2, hi, lo;
    logic [63:0] dv_result;
    logic        dv_ready;

    int total = 0;
    int bad   = 0;
    int we_count    = 0;
    int start_count = 0;

    always #5 clk = ~clk;

    div_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ex_div_i     (ex_div),
        .ex_signed_i  (ex_signed),
        .ex_op1_i     (ex_op1),
        .ex_op2_i     (ex_op2),
        .flush_i      (flush),
        .stall_o      (stall),
        .div_start_o  (div_start),
        .div_annul_o  (div_annul),
        .div_signed_o (div_signed),
        .div_op1_o    (div_op1),
        .div_op2_o    (div_op2),
        .div_result_i (dv_result),
        .div_ready_i  (dv_ready),
        .hilo_we_o    (hilo_we),
        .hi_o         (hi),
        .lo_o         (lo)
    );

    // Behavioural divider: free -> on (fixed iterations) -> end (hold until start drops).
    typedef enum logic [1:0] {DV_FREE, DV_ON, DV_END} dv_state_e;
    dv_state_e dv_state;
    int        dv_cnt;

    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, sq, sr;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = a; sb = b;
            sq = sa / sb;
            sr = sa % sb;
            return {sr, sq};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            dv_state  <= DV_FREE;
            dv_ready  <= 1'b0;
            dv_cnt    <= 0;
            dv_result <= '0;
        end else begin
            case (dv_state)
                DV_FREE: if (div_start && !div_annul) begin
                    dv_state  <= DV_ON;
                    dv_cnt    <= 0;
                    dv_result <= ref_div(div_signed, div_op1, div_op2);
                end
                DV_ON: begin
                    if (div_annul || !div_start) dv_state <= DV_FREE;
                    else if (dv_cnt == 31) begin
                        dv_state <= DV_END;
                        dv_ready <= 1'b1;
                    end else dv_cnt <= dv_cnt + 1;
                end
                default: if (div_annul || !div_start) begin
                    dv_state <= DV_FREE;
                    dv_ready <= 1'b0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (hilo_we)   we_count    <= we_count + 1;
        if (div_start) start_count <= start_count + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full division through the divider; returns positioned in the DRAIN cycle.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic nxt, input logic [31:0] na, input logic [31:0] nb);
        int   n;
        logic held, got;
        @(negedge clk);
        ex_div = 1'b1; ex_signed = sgn; ex_op1 = a; ex_op2 = b; flush = 1'b0;
        #1 check({tag, "_accept_stall"}, stall, 1);
        @(negedge clk); #1;
        check({tag, "_start"}, div_start, 1);
        check({tag, "_latched"}, {div_signed, div_op1, div_op2}, {sgn, a, b});
        n = 1; held = 1'b1; got = 1'b0;
        while (n < 60 && !got) begin
            if (dv_ready) got = 1'b1;
            else begin
                if (!stall) held = 1'b0;
                @(negedge clk); #1;
                n++;
            end
        end
        check({tag, "_ready_seen"}, got, 1);
        check({tag, "_latency_le40"}, (n <= 40), 1);
        check({tag, "_stall_held"}, held, 1);
        check({tag, "_ready_stall"}, stall, 0);
        @(negedge clk);
        ex_div = nxt; ex_signed = 1'b0; ex_op1 = na; ex_op2 = nb;
        #1;
        check({tag, "_we"}, hilo_we, 1);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_drain_start"}, div_start, 0);
        check({tag, "_drain_stall"}, stall, nxt);
    endtask

    typedef struct {
        logic        sgn;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    vec_t tv[6];
    int   base_we, base_start;

    initial begin
        tv[0] = '{1'b0, 32'd100,        32'd7,          32'd2,          32'd14};
        tv[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD};
        tv[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD};
        tv[3] = '{1'b0, 32'd5,          32'd0,          32'd0,          32'd0};
        tv[4] = '{1'b0, 32'hFFFF_FFFF,  32'h10,         32'hF,          32'h0FFF_FFFF};
        tv[5] = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFF2};

        repeat (3) @(negedge clk);
        #1;
        check("rst_regs", {div_start, div_annul, div_signed, hilo_we, div_op1, div_op2}, '0);
        check("rst_hilo", {hi, lo}, '0);
        rst = 1'b0;
        @(negedge clk); #1;
        check("idle_stall", stall, 0);

        // Flush while EX offers a DIV in IDLE: nothing starts, no stall.
        @(negedge clk);
        ex_div = 1'b1; flush = 1'b1; ex_op1 = 32'd4; ex_op2 = 32'd2;
        #1 check("flush_idle_stall", stall, 0);
        @(negedge clk);
        ex_div = 1'b0; flush = 1'b0;
        #1 check("flush_idle_nostart", div_start, 0);

        for (int i = 0; i < 6; i++) begin
            base_we = we_count;
            do_div($sformatf("vec%0d", i), tv[i].sgn, tv[i].a, tv[i].b, tv[i].hi, tv[i].lo, 1'b0, '0, '0);
            @(negedge clk); #1;
            check($sformatf("vec%0d_divider_free", i), (dv_state == DV_FREE), 1);
            check($sformatf("vec%0d_one_write", i), we_count, base_we + 1);
            repeat (2) @(negedge clk);
        end

        // Flush ten cycles into DIV 1000/3.
        base_we = we_count;
        @(negedge clk);
        ex_div = 1'b1; ex_signed = 1'b1; ex_op1 = 32'd1000; ex_op2 = 32'd3;
        repeat (10) @(negedge clk);
        flush = 1'b1; ex_div = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("abort_annul", div_annul, 1);
        check("abort_start", div_start, 0);
        check("abort_stall", stall, 0);
        @(negedge clk); #1;
        check("abort_annul_drop", div_annul, 0);
        check("abort_no_we", hilo_we, 0);
        do_div("after_flush", 1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, '0, '0);
        @(negedge clk); #1;
        check("flush_no_extra_write", we_count, base_we + 1);
        repeat (2) @(negedge clk);

        // Back-to-back: second DIVU offered during DRAIN, accepted in the next IDLE.
        base_we = we_count;
        do_div("b2b_first", 1'b0, 32'd8, 32'd2, 32'd0, 32'd4, 1'b1, 32'd9, 32'd4);
        do_div("b2b_second", 1'b0, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0, '0, '0);
        @(negedge clk); #1;
        check("b2b_two_writes", we_count, base_we + 2);

`ifdef DIV_FAST_PATH_EN
        repeat (2) @(negedge clk);
        base_we = we_count; base_start = start_count;
        @(negedge clk);
        ex_div = 1'b1; ex_signed = 1'b1; ex_op1 = 32'h8000_0000; ex_op2 = 32'd1;
        #1 check("fast_accept_stall", stall, 1);
        @(negedge clk); #1;
        check("fast_we", hilo_we, 1);
        check("fast_lo", lo, 32'h8000_0000);
        check("fast_hi", hi, 32'd0);
        check("fast_drain_stall", stall, 0);
        @(negedge clk);
        ex_div = 1'b0;
        #1;
        check("fast_no_start", start_count, base_start);
        check("fast_one_write", we_count, base_we + 1);
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
